// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants, FSM state encoding and BCD helpers for the UART command decoder.
package uart_cmd_pkg;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam int DIGITS      = 6;
  localparam int DIGIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    EOL  = 2'd2
  } state_t;

  // Upper-case letter constant matched in either case (bit 5 is the ASCII case bit).
  function automatic logic is_letter(input logic [7:0] b, input logic [7:0] ch);
    return (b == ch) || (b == (ch | 8'h20));
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  // tens*10 + ones built as tens*8 + tens*2 + ones so no multiplier is inferred.
  function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction
endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles and flags the last allowed cycle of a frame.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + CNT_W'(1);
  end

  assign expire = enable && (count == LAST);
endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: single-char pulses plus 'T' HHMMSS <CR|LF> time-set frames.
// Optional byte echo to the UART transmitter is enabled by defining CMD_ECHO_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned HOUR_MAX       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_err,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);
  state_t                 state, state_nxt;
  logic [DIGIT_CNT_W-1:0] digit_cnt, cnt_nxt;
  logic [3:0]             digit [DIGITS];
  logic                   digit_we;
  logic                   run_nxt, clear_nxt, mode_nxt, valid_nxt, err_nxt;
  logic [6:0]             hour_bin, min_bin, sec_bin;
  logic                   range_ok;
  logic                   expire;

  cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_done || (state == IDLE)),
    .enable (state != IDLE),
    .expire (expire)
  );

  assign hour_bin = bcd_pair(digit[0], digit[1]);
  assign min_bin  = bcd_pair(digit[2], digit[3]);
  assign sec_bin  = bcd_pair(digit[4], digit[5]);
  assign range_ok = ({25'd0, hour_bin} < HOUR_MAX) && (min_bin < 7'd60) && (sec_bin < 7'd60);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = digit_cnt;
    digit_we  = 1'b0;
    run_nxt   = 1'b0;
    clear_nxt = 1'b0;
    mode_nxt  = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (rx_done) begin
      case (state)
        IDLE: begin
          if (is_letter(rx_data, CH_R))      run_nxt   = 1'b1;
          else if (is_letter(rx_data, CH_C)) clear_nxt = 1'b1;
          else if (is_letter(rx_data, CH_M)) mode_nxt  = 1'b1;
          else if (is_letter(rx_data, CH_T)) begin
            state_nxt = SET;
            cnt_nxt   = '0;
          end else if (!is_eol(rx_data))     err_nxt   = 1'b1;
        end
        SET: begin
          if (is_digit(rx_data)) begin
            digit_we = 1'b1;
            cnt_nxt  = digit_cnt + DIGIT_CNT_W'(1);
            if (digit_cnt == DIGIT_CNT_W'(DIGITS - 1)) state_nxt = EOL;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        EOL: begin
          if (is_eol(rx_data) && range_ok) valid_nxt = 1'b1;
          else                             err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (expire) begin
      // A byte arriving in the expiry cycle takes priority over the abort.
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digit_cnt <= '0;
      // NOTE: the digit file is small and explicitly cleared so reset state is fully defined.
      for (int i = 0; i < DIGITS; i++) digit[i] <= '0;
      cmd_run   <= 1'b0;
      cmd_clear <= 1'b0;
      cmd_mode  <= 1'b0;
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
    end else begin
      state     <= state_nxt;
      digit_cnt <= cnt_nxt;
      if (digit_we) digit[digit_cnt] <= rx_data[3:0];
      cmd_run   <= run_nxt;
      cmd_clear <= clear_nxt;
      cmd_mode  <= mode_nxt;
      set_valid <= valid_nxt;
      cmd_err   <= err_nxt;
      busy      <= (state_nxt != IDLE);
      if (valid_nxt) begin
        set_hour <= hour_bin[4:0];
        set_min  <= min_bin[5:0];
        set_sec  <= sec_bin[5:0];
      end
    end
  end

`ifdef CMD_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= rx_done && !tx_busy;
      if (rx_done && !tx_busy) tx_data <= rx_data;
    end
  end
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_start       = 1'b0;
  assign tx_data        = '0;
`endif
endmodule
